// File: rtl/iir_sched_pkg.sv
// iir_sched_pkg: shared types, defaults and helpers
// for the time-shared IIR MACC scheduler.
package iir_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      TAP,
      DRAIN,
      WB
   } state_t;

   localparam int NCH_DEF      = 4;
   localparam int NTAP_DEF     = 5;
   localparam int MACC_LAT_DEF = 1;

   function automatic int coeff_addr(
      int ch,
      int tap,
      int ntap = NTAP_DEF
   );
      return ch * ntap + tap;
   endfunction

endpackage

// File: rtl/iir_macc_scheduler_if.sv
// iir_macc_scheduler_if: frame handshake plus datapath strobes.
// ch_mask exists only with IIR_SCHED_CH_MASK_EN.
interface iir_macc_scheduler_if #(
   parameter int NCH  = iir_sched_pkg::NCH_DEF,
   parameter int NTAP = iir_sched_pkg::NTAP_DEF
);
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TAP_W = (NTAP > 1) ? $clog2(NTAP) : 1;
   localparam int CA_W  = (NCH * NTAP > 1) ? $clog2(NCH * NTAP) : 1;

   logic             start;
   logic             start_ready;
   logic             clr_overrun;
   logic [CH_W-1:0]  ch;
   logic [TAP_W-1:0] tap_dir;
   logic [CA_W-1:0]  coeff_dir;
   logic             macc_clr;
   logic             macc_en;
   logic             x_wr_en;
   logic             y_wr_en;
   logic             out_valid;
   logic [CH_W-1:0]  out_ch;
   logic             done;
   logic             overrun;
`ifdef IIR_SCHED_CH_MASK_EN
   logic [NCH-1:0]   ch_mask;
`endif

   modport master (
`ifdef IIR_SCHED_CH_MASK_EN
      input  ch_mask,
`endif
      input  start, clr_overrun,
      output start_ready, ch, tap_dir, coeff_dir,
      output macc_clr, macc_en, x_wr_en, y_wr_en,
      output out_valid, out_ch, done, overrun
   );

   modport slave (
`ifdef IIR_SCHED_CH_MASK_EN
      output ch_mask,
`endif
      output start, clr_overrun,
      input  start_ready, ch, tap_dir, coeff_dir,
      input  macc_clr, macc_en, x_wr_en, y_wr_en,
      input  out_valid, out_ch, done, overrun
   );

endinterface

// File: rtl/iir_sched_ch_seq.sv
// iir_sched_ch_seq: picks the next channel to process.
// With IIR_SCHED_CH_MASK_EN it searches the mask for the lowest enabled channel.
module iir_sched_ch_seq #(
   parameter int NCH = 4,
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
`ifdef IIR_SCHED_CH_MASK_EN
   input  logic [NCH-1:0]  mask,
`endif
   input  logic [CH_W-1:0] ch,
   input  logic            scan_all,
   output logic [CH_W-1:0] nxt_ch,
   output logic            nxt_none
);

`ifdef IIR_SCHED_CH_MASK_EN
   // lowest enabled channel above ch (or from 0 when scanning all)
   always_comb begin
      nxt_ch   = '0;
      nxt_none = 1'b1;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (mask[i] && (scan_all || i > int'(ch))) begin
            nxt_ch   = CH_W'(i);
            nxt_none = 1'b0;
         end
      end
   end
`else
   // plain increment; the last channel ends the frame
   always_comb begin
      nxt_ch   = scan_all ? '0 : ch + CH_W'(1);
      nxt_none = !scan_all && (ch == CH_W'(NCH - 1));
   end
`endif

endmodule

// File: rtl/iir_macc_scheduler.sv
// iir_macc_scheduler: shares one MACC/ROM/history memory across NCH IIR channels.
// Optional channel skipping is enabled by defining IIR_SCHED_CH_MASK_EN.
module iir_macc_scheduler
   import iir_sched_pkg::*;
#(
   parameter int NCH      = NCH_DEF,
   parameter int NTAP     = NTAP_DEF,
   parameter int MACC_LAT = MACC_LAT_DEF
) (
   input logic fclk,
   input logic reset,
   iir_macc_scheduler_if.master bus
);

   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TAP_W = (NTAP > 1) ? $clog2(NTAP) : 1;
   localparam int CA_W  = (NCH * NTAP > 1) ? $clog2(NCH * NTAP) : 1;
   localparam int DR_W  = 3;
   localparam logic [DR_W-1:0] DR_LOAD =
      DR_W'((MACC_LAT > 0) ? MACC_LAT - 1 : 0);

   state_t           state_q, state_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [TAP_W-1:0] tap_q, tap_d;
   logic [CA_W-1:0]  coeff_q, coeff_d;
   logic [DR_W-1:0]  drain_q, drain_d;
   logic             ov_q, ov_d;
   logic             empty_q, empty_d;
   logic [CH_W-1:0]  nxt_ch;
   logic             nxt_none;
   logic             in_idle;

   assign in_idle = (state_q == IDLE);

`ifdef IIR_SCHED_CH_MASK_EN
   logic [NCH-1:0] mask_q;
   logic [NCH-1:0] mask_sel;

   // latch the channel mask when a frame is accepted
   always_ff @(posedge fclk or posedge reset) begin
      if (reset)
         mask_q <= '0;
      else if (in_idle && bus.start)
         mask_q <= bus.ch_mask;
   end

   assign mask_sel = in_idle ? bus.ch_mask : mask_q;
`endif

   iir_sched_ch_seq #(.NCH(NCH)) u_seq (
`ifdef IIR_SCHED_CH_MASK_EN
      .mask     (mask_sel),
`endif
      .ch       (ch_q),
      .scan_all (in_idle),
      .nxt_ch   (nxt_ch),
      .nxt_none (nxt_none)
   );

   // state and counter registers
   always_ff @(posedge fclk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ch_q    <= '0;
         tap_q   <= '0;
         coeff_q <= '0;
         drain_q <= '0;
         ov_q    <= 1'b0;
         empty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         tap_q   <= tap_d;
         coeff_q <= coeff_d;
         drain_q <= drain_d;
         ov_q    <= ov_d;
         empty_q <= empty_d;
      end
   end

   // next-state, counters and sticky overrun
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      tap_d   = tap_q;
      coeff_d = coeff_q;
      drain_d = drain_q;
      empty_d = 1'b0;
      ov_d    = ov_q;
      if (bus.clr_overrun)
         ov_d = 1'b0;
      if (bus.start && !in_idle)
         ov_d = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (nxt_none) begin
                  empty_d = 1'b1;
               end else begin
                  ch_d    = nxt_ch;
                  state_d = CLR;
               end
            end
         end
         CLR: begin
            tap_d   = '0;
            coeff_d = CA_W'(coeff_addr(int'(ch_q), 0, NTAP));
            state_d = TAP;
         end
         TAP: begin
            if (tap_q == TAP_W'(NTAP - 1)) begin
               if (MACC_LAT > 0) begin
                  drain_d = DR_LOAD;
                  state_d = DRAIN;
               end else begin
                  state_d = WB;
               end
            end else begin
               tap_d   = tap_q + TAP_W'(1);
               coeff_d = coeff_q + CA_W'(1);
            end
         end
         DRAIN: begin
            if (drain_q == '0)
               state_d = WB;
            else
               drain_d = drain_q - DR_W'(1);
         end
         WB: begin
            if (nxt_none) begin
               state_d = IDLE;
            end else begin
               ch_d    = nxt_ch;
               state_d = CLR;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // outputs decoded from registered state only
   always_comb begin
      bus.start_ready = in_idle;
      bus.macc_clr    = (state_q == CLR);
      bus.macc_en     = (state_q == TAP);
      bus.x_wr_en     = (state_q == WB);
      bus.y_wr_en     = (state_q == WB);
      bus.out_valid   = (state_q == WB);
      bus.out_ch      = (state_q == WB) ? ch_q : '0;
      bus.done        = ((state_q == WB) && nxt_none) || empty_q;
      bus.ch          = ch_q;
      bus.tap_dir     = tap_q;
      bus.coeff_dir   = coeff_q;
      bus.overrun     = ov_q;
   end

endmodule

// File: tb/tb_iir_macc_scheduler.sv
// tb_iir_macc_scheduler: scoreboard bench for iir_macc_scheduler.
// Default DUT (4ch, lat 1) plus a 2ch, lat 3 DUT.
module tb_iir_macc_scheduler;

   logic fclk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_fail = 0;
   int   exp_och[$];
   int   exp_ocyc[$];
   int   exp_coeff[$];
   int   exp_done[$];

   iir_macc_scheduler_if #(.NCH(4), .NTAP(5)) b0 ();
   iir_macc_scheduler_if #(.NCH(2), .NTAP(5)) b1 ();

   iir_macc_scheduler #(.NCH(4), .NTAP(5), .MACC_LAT(1)) dut (
      .fclk  (fclk),
      .reset (reset),
      .bus   (b0)
   );

   iir_macc_scheduler #(.NCH(2), .NTAP(5), .MACC_LAT(3)) dut2 (
      .fclk  (fclk),
      .reset (reset),
      .bus   (b1)
   );

   always #5 fclk = ~fclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic test_reset;
      reset = 1'b1;
      b0.start = 1'b0;
      b0.clr_overrun = 1'b0;
      b1.start = 1'b0;
      b1.clr_overrun = 1'b0;
`ifdef IIR_SCHED_CH_MASK_EN
      b0.ch_mask = 4'hF;
      b1.ch_mask = 2'h3;
`endif
      #1;
      n_chk++;
      if (b0.start_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready got %b want 1", b0.start_ready);
      end
      n_chk++;
      if ({b0.macc_clr, b0.macc_en, b0.x_wr_en, b0.y_wr_en,
           b0.out_valid, b0.done, b0.overrun} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_strobes got %b want 0",
            {b0.macc_clr, b0.macc_en, b0.x_wr_en, b0.y_wr_en,
             b0.out_valid, b0.done, b0.overrun});
      end
      n_chk++;
      if (int'(b0.ch) !== 0 || int'(b0.coeff_dir) !== 0 || int'(b0.out_ch) !== 0) begin
         n_fail++;
         $display("FAIL reset_ch got ch=%0d coeff=%0d want 0", b0.ch, b0.coeff_dir);
      end
      @(negedge fclk);
      @(negedge fclk);
      reset = 1'b0;
      @(negedge fclk);
   endtask

   task automatic test_frame(input string tag);
      int macc_cnt [4];
      int clr_cnt;
      int done_cyc;
      bit wr_bad;
      int e;
      int ec;
      clr_cnt = 0;
      done_cyc = -1;
      wr_bad = 1'b0;
      for (int c = 0; c < 4; c++) begin
         macc_cnt[c] = 0;
         exp_och.push_back(c);
         exp_ocyc.push_back(8 * (c + 1));
         for (int t = 0; t < 5; t++)
            exp_coeff.push_back(c * 5 + t);
      end
      @(negedge fclk);
      b0.start = 1'b1;
      @(negedge fclk);
      b0.start = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (cyc > 1)
            @(negedge fclk);
         if (cyc == 1) begin
            n_chk++;
            if (b0.start_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL %s ready_drop got %b want 0", tag, b0.start_ready);
            end
         end
         if (b0.macc_clr === 1'b1)
            clr_cnt++;
         if (b0.macc_en === 1'b1) begin
            macc_cnt[b0.ch]++;
            n_chk++;
            if (exp_coeff.size() == 0) begin
               n_fail++;
               $display("FAIL %s coeff_extra got %0d want none", tag, b0.coeff_dir);
            end else begin
               e = exp_coeff.pop_front();
               if (int'(b0.coeff_dir) !== e) begin
                  n_fail++;
                  $display("FAIL %s coeff_dir got %0d want %0d", tag, b0.coeff_dir, e);
               end
            end
         end
         if (b0.out_valid === 1'b1) begin
            n_chk++;
            if (exp_och.size() == 0) begin
               n_fail++;
               $display("FAIL %s out_extra got ch %0d want none", tag, b0.out_ch);
            end else begin
               e = exp_och.pop_front();
               ec = exp_ocyc.pop_front();
               if (int'(b0.out_ch) !== e || cyc !== ec) begin
                  n_fail++;
                  $display("FAIL %s out got ch%0d@%0d want ch%0d@%0d",
                     tag, b0.out_ch, cyc, e, ec);
               end
            end
         end
         if (b0.x_wr_en !== b0.out_valid || b0.y_wr_en !== b0.out_valid)
            wr_bad = 1'b1;
         if (b0.done === 1'b1 && done_cyc < 0)
            done_cyc = cyc;
      end
      n_chk++;
      if (done_cyc !== 32) begin
         n_fail++;
         $display("FAIL %s done_cycle got %0d want 32", tag, done_cyc);
      end
      for (int c = 0; c < 4; c++) begin
         n_chk++;
         if (macc_cnt[c] !== 5) begin
            n_fail++;
            $display("FAIL %s macc_en_ch%0d got %0d want 5", tag, c, macc_cnt[c]);
         end
      end
      n_chk++;
      if (clr_cnt !== 4 || wr_bad) begin
         n_fail++;
         $display("FAIL %s clr_wr got clr=%0d wr_bad=%0b want 4,0", tag, clr_cnt, wr_bad);
      end
      n_chk++;
      if (exp_och.size() != 0 || exp_coeff.size() != 0) begin
         n_fail++;
         $display("FAIL %s leftover got out=%0d coeff=%0d want 0,0",
            tag, exp_och.size(), exp_coeff.size());
      end
      exp_och.delete();
      exp_ocyc.delete();
      exp_coeff.delete();
   endtask

   task automatic test_drain;
      int quiet;
      int done_cyc;
      bit clash;
      int e;
      int ec;
      quiet = 0;
      done_cyc = -1;
      clash = 1'b0;
      exp_och.push_back(0);
      exp_ocyc.push_back(10);
      exp_och.push_back(1);
      exp_ocyc.push_back(20);
      @(negedge fclk);
      b1.start = 1'b1;
      @(negedge fclk);
      b1.start = 1'b0;
      for (int cyc = 1; cyc <= 25; cyc++) begin
         if (cyc > 1)
            @(negedge fclk);
         if (cyc <= 20 && !b1.macc_clr && !b1.macc_en && !b1.out_valid)
            quiet++;
         if (b1.y_wr_en === 1'b1 && b1.macc_en === 1'b1)
            clash = 1'b1;
         if (b1.out_valid === 1'b1) begin
            n_chk++;
            if (exp_och.size() == 0) begin
               n_fail++;
               $display("FAIL drain out_extra got ch %0d want none", b1.out_ch);
            end else begin
               e = exp_och.pop_front();
               ec = exp_ocyc.pop_front();
               if (int'(b1.out_ch) !== e || cyc !== ec) begin
                  n_fail++;
                  $display("FAIL drain out got ch%0d@%0d want ch%0d@%0d",
                     b1.out_ch, cyc, e, ec);
               end
            end
         end
         if (b1.done === 1'b1 && done_cyc < 0)
            done_cyc = cyc;
      end
      n_chk++;
      if (done_cyc !== 20) begin
         n_fail++;
         $display("FAIL drain done_cycle got %0d want 20", done_cyc);
      end
      n_chk++;
      if (quiet !== 6) begin
         n_fail++;
         $display("FAIL drain quiet_cycles got %0d want 6", quiet);
      end
      n_chk++;
      if (clash || exp_och.size() != 0) begin
         n_fail++;
         $display("FAIL drain ywr_macc got clash=%0b left=%0d want 0,0",
            clash, exp_och.size());
      end
      exp_och.delete();
      exp_ocyc.delete();
   endtask

   task automatic test_back_to_back;
      int e;
      exp_done.push_back(32);
      exp_done.push_back(65);
      @(negedge fclk);
      b0.start = 1'b1;
      @(negedge fclk);
      for (int cyc = 1; cyc <= 65; cyc++) begin
         if (cyc > 1)
            @(negedge fclk);
         if (cyc == 2 || cyc == 11 || cyc == 50) begin
            n_chk++;
            if (b0.overrun !== 1'b1) begin
               n_fail++;
               $display("FAIL overrun_c%0d got %b want 1", cyc, b0.overrun);
            end
         end
         if (cyc == 10)
            b0.clr_overrun = 1'b1;
         if (cyc == 11)
            b0.clr_overrun = 1'b0;
         if (cyc == 33) begin
            n_chk++;
            if (b0.start_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL idle_reentry got %b want 1", b0.start_ready);
            end
         end
         if (cyc == 34) begin
            n_chk++;
            if (b0.macc_clr !== 1'b1 || b0.start_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL reaccept got clr=%b rdy=%b want 1,0",
                  b0.macc_clr, b0.start_ready);
            end
         end
         if (b0.done === 1'b1) begin
            n_chk++;
            if (exp_done.size() == 0) begin
               n_fail++;
               $display("FAIL b2b done_extra got cycle %0d want none", cyc);
            end else begin
               e = exp_done.pop_front();
               if (cyc !== e) begin
                  n_fail++;
                  $display("FAIL b2b done got %0d want %0d", cyc, e);
               end
            end
         end
         if (cyc == 65)
            b0.start = 1'b0;
      end
      n_chk++;
      if (exp_done.size() != 0) begin
         n_fail++;
         $display("FAIL b2b done_missing got %0d left want 0", exp_done.size());
      end
      exp_done.delete();
      @(negedge fclk);
      b0.clr_overrun = 1'b1;
      @(negedge fclk);
      b0.clr_overrun = 1'b0;
      n_chk++;
      if (b0.overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_clear got %b want 0", b0.overrun);
      end
   endtask

   task automatic test_reset_mid;
      int wr_cnt;
      bit late_wr;
      wr_cnt = 0;
      late_wr = 1'b0;
      @(negedge fclk);
      b0.start = 1'b1;
      @(negedge fclk);
      b0.start = 1'b0;
      for (int cyc = 1; cyc <= 19; cyc++) begin
         if (cyc > 1)
            @(negedge fclk);
         if (b0.y_wr_en === 1'b1)
            wr_cnt++;
      end
      n_chk++;
      if (int'(b0.ch) !== 2 || b0.macc_en !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_tap got ch=%0d en=%b want 2,1", b0.ch, b0.macc_en);
      end
      #1;
      reset = 1'b1;
      #1;
      n_chk++;
      if ({b0.macc_clr, b0.macc_en, b0.x_wr_en, b0.y_wr_en,
           b0.out_valid, b0.done} !== 6'b0 || b0.start_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset got strobes=%b rdy=%b want 0,1",
            {b0.macc_clr, b0.macc_en, b0.x_wr_en, b0.y_wr_en,
             b0.out_valid, b0.done}, b0.start_ready);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge fclk);
         if (b0.x_wr_en === 1'b1 || b0.y_wr_en === 1'b1)
            late_wr = 1'b1;
      end
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge fclk);
         if (b0.x_wr_en === 1'b1 || b0.y_wr_en === 1'b1)
            late_wr = 1'b1;
      end
      n_chk++;
      if (wr_cnt !== 2 || late_wr) begin
         n_fail++;
         $display("FAIL reset_writes got pre=%0d late=%0b want 2,0", wr_cnt, late_wr);
      end
      test_frame("post_reset");
   endtask

`ifdef IIR_SCHED_CH_MASK_EN
   task automatic test_mask_partial;
      int done_cyc;
      int e;
      int ec;
      done_cyc = -1;
      exp_och.push_back(1);
      exp_ocyc.push_back(8);
      exp_och.push_back(3);
      exp_ocyc.push_back(16);
      @(negedge fclk);
      b0.ch_mask = 4'b1010;
      b0.start = 1'b1;
      @(negedge fclk);
      b0.start = 1'b0;
      b0.ch_mask = 4'hF;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         if (cyc > 1)
            @(negedge fclk);
         if (b0.out_valid === 1'b1) begin
            n_chk++;
            if (exp_och.size() == 0) begin
               n_fail++;
               $display("FAIL mask out_extra got ch %0d want none", b0.out_ch);
            end else begin
               e = exp_och.pop_front();
               ec = exp_ocyc.pop_front();
               if (int'(b0.out_ch) !== e || cyc !== ec) begin
                  n_fail++;
                  $display("FAIL mask out got ch%0d@%0d want ch%0d@%0d",
                     b0.out_ch, cyc, e, ec);
               end
            end
         end
         if (b0.done === 1'b1 && done_cyc < 0)
            done_cyc = cyc;
      end
      n_chk++;
      if (done_cyc !== 16 || exp_och.size() != 0) begin
         n_fail++;
         $display("FAIL mask done got %0d left=%0d want 16,0", done_cyc, exp_och.size());
      end
      exp_och.delete();
      exp_ocyc.delete();
   endtask

   task automatic test_mask_none;
      int done_cyc;
      int done_n;
      bit busy;
      done_cyc = -1;
      done_n = 0;
      busy = 1'b0;
      @(negedge fclk);
      b0.ch_mask = 4'b0000;
      b0.start = 1'b1;
      @(negedge fclk);
      b0.start = 1'b0;
      b0.ch_mask = 4'hF;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         if (cyc > 1)
            @(negedge fclk);
         if (b0.macc_clr === 1'b1 || b0.macc_en === 1'b1 || b0.out_valid === 1'b1)
            busy = 1'b1;
         if (b0.done === 1'b1) begin
            done_n++;
            if (done_cyc < 0)
               done_cyc = cyc;
         end
      end
      n_chk++;
      if (done_cyc !== 1 || done_n !== 1 || busy) begin
         n_fail++;
         $display("FAIL mask_empty got done@%0d n=%0d busy=%0b want 1,1,0",
            done_cyc, done_n, busy);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_frame("frame");
      test_drain();
      test_back_to_back();
      test_reset_mid();
`ifdef IIR_SCHED_CH_MASK_EN
      test_mask_partial();
      test_mask_none();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/iir_macc_scheduler.md
Name: iir_macc_scheduler

Overview:
- Time-shares one multiply-accumulate unit, one coefficient ROM and one sample/history memory across NCH independent IIR channels.
- Each frame (one new sample per channel) it sequences, per channel: accumulator clear, NTAP MAC cycles, pipeline drain, then history/output write-back.
- Sits between the frame-level sample strobe from the acquisition front end and the shared filter datapath.
- Replaces per-channel fixed FSMs, so one MACC serves all channels.

Parameters:
- NCH, 4: number of channels sharing the datapath (1..16).
- NTAP, 5: MAC cycles per channel per frame. Default is b0·x, b1·x1, b2·x2, a1·y1, a2·y2.
- MACC_LAT, 1: MACC pipeline latency, in cycles from the last macc_en until the product is valid at the MACC output (0..4).
- CH_W, max(1,$clog2(NCH)): channel index width.
- TAP_W, max(1,$clog2(NTAP)): tap index width.
- CA_W, max(1,$clog2(NCH*NTAP)): coefficient address width.

Ports:
- fclk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  frame request; accepted only when start_ready=1.
- start_ready  out  1  high in IDLE only.
- clr_overrun  in  1  clears the overrun flag.
- ch  out  CH_W  channel currently being processed.
- tap_dir  out  TAP_W  history/sample mux address for the shared memory block.
- coeff_dir  out  CA_W  coefficient ROM address, equal to ch*NTAP+tap.
- macc_clr  out  1  accumulator clear.
- macc_en  out  1  accumulate enable.
- x_wr_en  out  1  shift the x history for channel ch.
- y_wr_en  out  1  latch the MACC result into the y history/output register for channel ch.
- out_valid  out  1  filtered sample for out_ch is valid this cycle.
- out_ch  out  CH_W  channel tag for out_valid.
- done  out  1  one-cycle pulse; frame complete.
- overrun  out  1  sticky: start was seen while not ready.

Behaviour:
- Reset (async, active-high): state IDLE; ch, tap and drain counter cleared to 0; all outputs 0 except start_ready=1; overrun cleared.
- Outputs are registered, or decoded from registered state only. Nothing is combinational from start.
- States and transitions:
  - IDLE: start_ready=1. If start=1, set ch=0 and go to CLR.
  - CLR (1 cycle): macc_clr=1. Set tap=0, go to TAP.
  - TAP (NTAP cycles): macc_en=1, tap_dir=tap, coeff_dir=ch*NTAP+tap. tap increments each cycle. At tap==NTAP-1: go to DRAIN if MACC_LAT>0, otherwise go to WB.
  - DRAIN (MACC_LAT cycles): all strobes low; counter counts down. At 0, go to WB.
  - WB (1 cycle): x_wr_en=1, y_wr_en=1, out_valid=1, out_ch=ch.
    - If ch==NCH-1: done=1, go to IDLE.
    - Otherwise: ch+1, go to CLR.
- Frame latency from start accept to done = NCH*(NTAP+MACC_LAT+2) cycles, which is 32 at the defaults. IDLE re-entry costs 1 extra cycle before the next start_ready.
- tap_dir and coeff_dir hold their last value outside TAP; consumers must gate on macc_en.
- start while start_ready=0 (any non-IDLE state, including the WB cycle carrying done) sets overrun and is otherwise ignored. The request is not queued.
- If clr_overrun and a new overrun event occur in the same cycle, set wins.
- ch and coeff_dir never exceed NCH-1 and NCH*NTAP-1 respectively. No wrap-around occurs inside a frame.
- Reset mid-frame aborts immediately. No write strobe fires after reset asserts. Partial accumulator contents are discarded by the next CLR.

Optional Feature:
- Macro: IIR_SCHED_CH_MASK_EN.
- When defined, an input port ch_mask [NCH-1:0] is added and sampled on start acceptance. Channels with a mask bit of 0 are skipped entirely: no CLR, TAP, DRAIN or WB cycles and no out_valid. The next enabled channel proceeds from IDLE or WB directly to its CLR.
- If all mask bits are 0, done pulses one cycle after start acceptance with no other strobes.
- Frame latency equals (number of enabled channels)*(NTAP+MACC_LAT+2), plus 1 when all channels are masked.
- When not defined, there is no port and every channel is processed.

Decomposition:
- Package iir_sched_pkg holds:
  - the state enum typedef (IDLE, CLR, TAP, DRAIN, WB);
  - the default NCH/NTAP/MACC_LAT constants;
  - a function coeff_addr(ch,tap) returning ch*NTAP+tap.
- One sub-module, iir_sched_ch_seq: the next-enabled-channel finder. It is a priority search over the latched mask above the current ch. Without the macro it reduces to ch+1 and a last-channel flag.

Test Plan:
- Defaults, single start pulse:
  - start_ready drops next cycle; done 32 cycles after acceptance.
  - out_valid pulses with out_ch=0,1,2,3 at cycles 8,16,24,32.
  - Per channel: macc_en high for exactly 5 cycles, with coeff_dir 0..4, 5..9, 10..14, 15..19.
- MACC_LAT=3, NCH=2: 2 macc_en-free DRAIN cycles added per channel relative to MACC_LAT=1; done at cycle 20. y_wr_en never coincides with macc_en.
- start held high continuously (defaults):
  - overrun asserts on the cycle after the first acceptance and stays high.
  - A new frame is accepted on each IDLE cycle.
  - clr_overrun pulsed in the same cycle as a busy start leaves overrun=1.
- Reset asserted asynchronously mid-TAP of channel 2: all strobes 0 and start_ready=1 immediately. No x_wr_en/y_wr_en seen for channel 2. The next start processes channels 0..3 normally.
- IIR_SCHED_CH_MASK_EN, ch_mask=4'b1010: only out_ch 1 and 3 appear; done at cycle 16.
- IIR_SCHED_CH_MASK_EN, ch_mask=0: done pulses exactly 1 cycle after acceptance, with no macc_clr, macc_en or out_valid.
